// File: rtl/seq_detect_moore_param_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Package     : seq_det_pkg
//  Description : Shared types and helpers for the parametrised Moore serial
//                sequence detector (state encoding, pattern length limit,
//                fill-counter width calculation).
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package seq_det_pkg;

   // Longest pattern the detector is qualified for.
   localparam int MAX_PAT_LEN = 16;

   // Width of the detector state register.
   localparam int STATE_W = 2;

   // FILL  : window not yet holding PAT_LEN valid bits.
   // ARMED : window full, the most recent window did not match.
   // HIT   : the most recent accepted bit completed a match (y = 1).
   typedef enum logic [STATE_W-1:0] {
      FILL  = 2'd0,
      ARMED = 2'd1,
      HIT   = 2'd2
   } state_t;

   // The fill counter must represent 0..pat_len inclusive.
   function automatic int fill_width(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_detect_moore_param_if.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Interface   : seq_detect_moore_param_if
//  Description : Serial input, pattern load and match result signals of the
//                sequence detector. The master modport belongs to the
//                upstream bit-recovery / control side, the slave modport to
//                the detector itself.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface seq_detect_moore_param_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) ();

   logic               din_valid;
   logic               din;
   logic               pat_load;
   logic [PAT_LEN-1:0] pat_in;
   logic               y;
   logic [CNT_W-1:0]   match_count;

   modport master (
      output din_valid,
      output din,
      output pat_load,
      output pat_in,
      input  y,
      input  match_count
   );

   modport slave (
      input  din_valid,
      input  din,
      input  pat_load,
      input  pat_in,
      output y,
      output match_count
   );

endinterface : seq_detect_moore_param_if
`default_nettype wire

// File: rtl/seq_detect_moore_param_window.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : seq_det_window
//  Description : Sliding bit window of the sequence detector. Holds the last
//                PAT_LEN accepted bits in a shift register and counts how many
//                of them are valid (saturating at PAT_LEN). Presents the
//                window as it will look after the current bit so the FSM can
//                decide on a match in the same cycle the bit is sampled.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seq_det_window
   import seq_det_pkg::*;
#(
   parameter int PAT_LEN = 4
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               i_shift_en,
   input  wire logic               i_clear,
   input  wire logic               i_din,
   output logic      [PAT_LEN-1:0] o_next_history,
   output logic                    o_next_full
);

   localparam int FILL_W = fill_width(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] r_history;
   logic [FILL_W-1:0]  r_fill;
   logic [FILL_W-1:0]  w_next_fill;

   // Newest bit enters at the LSB, so the oldest bit sits at the MSB and
   // lines up with PATTERN[PAT_LEN-1].
   assign o_next_history = {r_history[PAT_LEN-2:0], i_din};

   // Fill count saturates once the window is full.
   assign w_next_fill = (r_fill == FILL_MAX) ? r_fill : (r_fill + FILL_W'(1));

   assign o_next_full = (w_next_fill == FILL_MAX);

   // Window storage: clear wins over shift so a flush on match entry empties
   // the window even though a bit was accepted in that same cycle.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_history <= '0;
         r_fill    <= '0;
      end else if (i_shift_en) begin
         r_history <= o_next_history;
         r_fill    <= w_next_fill;
      end
   end

endmodule : seq_det_window
`default_nettype wire

// File: rtl/seq_detect_moore_param.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : seq_detect_moore_param
//  Description : Parametrised Moore serial sequence detector. Compares the
//                last PAT_LEN accepted bits against a runtime-loadable
//                pattern and raises y for one cycle per match (repeating
//                while consecutive bits keep completing matches).
//                OVERLAP = 0 flushes the window on every match.
//  Options     : `define MATCH_CNT_EN to build the saturating match counter;
//                without it match_count is constant zero.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seq_detect_moore_param
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
   parameter int                 OVERLAP = 1,
   parameter int                 CNT_W   = 8
) (
   input  wire logic              clk,
   input  wire logic              reset,
   seq_detect_moore_param_if.slave bus
);

   // Reject pattern lengths the window and fill counter are not built for.
   if ((PAT_LEN < 2) || (PAT_LEN > MAX_PAT_LEN)) begin : g_bad_pat_len
      $error("seq_detect_moore_param: PAT_LEN %0d outside 2..%0d", PAT_LEN, MAX_PAT_LEN);
   end

   localparam logic FLUSH_ON_HIT = (OVERLAP == 0);

   logic [PAT_LEN-1:0] r_pattern;
   state_t             r_state;
   state_t             w_state_next;

   logic               w_accept;
   logic               w_match;
   logic               w_clear;
   logic [PAT_LEN-1:0] w_next_history;
   logic               w_next_full;

   // A pattern load takes priority over any bit offered in the same cycle.
   assign w_accept = bus.din_valid & ~bus.pat_load;

   // The window as it will be after this bit, full and equal to the pattern.
   assign w_match  = w_next_full & (w_next_history == r_pattern);

   // Window is emptied by a pattern load, and on match entry when overlap is
   // disabled so the next match needs PAT_LEN fresh bits.
   assign w_clear  = bus.pat_load | (FLUSH_ON_HIT & w_accept & w_match);

   seq_det_window #(
      .PAT_LEN        (PAT_LEN)
   ) u_window (
      .clk            (clk),
      .reset          (reset),
      .i_shift_en     (w_accept),
      .i_clear        (w_clear),
      .i_din          (bus.din),
      .o_next_history (w_next_history),
      .o_next_full    (w_next_full)
   );

   // Pattern register: default pattern on reset, replaced by pat_in on load.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pattern <= PATTERN;
      end else if (bus.pat_load) begin
         r_pattern <= bus.pat_in;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode: load forces FILL, accepted bits re-evaluate the
   // window, idle cycles only retire a HIT.
   always_comb begin
      w_state_next = r_state;
      if (bus.pat_load) begin
         w_state_next = FILL;
      end else if (w_accept) begin
         if (w_match) begin
            w_state_next = HIT;
         end else if (w_next_full) begin
            w_state_next = ARMED;
         end else begin
            w_state_next = FILL;
         end
      end else begin
         case (r_state)
            HIT:     w_state_next = FLUSH_ON_HIT ? FILL : ARMED;
            FILL:    w_state_next = FILL;
            ARMED:   w_state_next = ARMED;
            default: w_state_next = FILL;
         endcase
      end
   end

   // Moore output: decoded from the registered state only.
   assign bus.y = (r_state == HIT);

`ifdef MATCH_CNT_EN
   logic [CNT_W-1:0] r_match_count;

   // Saturating count of HIT entries; survives pattern loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_match_count <= '0;
      end else if (w_accept && w_match && (r_match_count != {CNT_W{1'b1}})) begin
         r_match_count <= r_match_count + CNT_W'(1);
      end
   end

   assign bus.match_count = r_match_count;
`else
   assign bus.match_count = '0;
`endif

endmodule : seq_detect_moore_param
`default_nettype wire

// File: tb/tb_seq_detect_moore_param.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_seq_detect_moore_param
//  Description : Self-checking bench. DUT A (OVERLAP=1) and DUT B (OVERLAP=0)
//                share a vector table; DUT C (PAT_LEN=3, 111, CNT_W=2) runs
//                hand-written sequences for repeated HIT, load-during-HIT and
//                counter saturation. Match counts are checked against zero
//                when MATCH_CNT_EN is not defined.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seq_detect_moore_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seq_detect_moore_param_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
   seq_detect_moore_param_if #(.PAT_LEN(4), .CNT_W(8)) if_b ();
   seq_detect_moore_param_if #(.PAT_LEN(3), .CNT_W(2)) if_c ();

   seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1), .CNT_W(8))
      dut_a (.clk(clk), .reset(rst), .bus(if_a.slave));
   seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(0), .CNT_W(8))
      dut_b (.clk(clk), .reset(rst), .bus(if_b.slave));
   seq_detect_moore_param #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2))
      dut_c (.clk(clk), .reset(rst), .bus(if_c.slave));

   typedef struct {
      logic       rst;
      logic       vld;
      logic       d;
      logic       ld;
      logic [3:0] pat;
      logic       ya;
      logic       yb;
      logic       chk;
      int         ca;
      int         cb;
   } vec_t;

   typedef struct {
      logic ya;
      logic yb;
      logic chk;
      int   ca;
      int   cb;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   sb_c[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic int ecnt(input int n);
`ifdef MATCH_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   function automatic void add(input logic r, input logic v, input logic d, input logic ld,
                               input logic [3:0] pat, input logic ya, input logic yb,
                               input logic chk, input int ca, input int cb);
      vec_t t;
      t.rst = r; t.vld = v; t.d = d; t.ld = ld; t.pat = pat;
      t.ya = ya; t.yb = yb; t.chk = chk; t.ca = ca; t.cb = cb;
      tbl.push_back(t);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_c(input logic r, input logic v, input logic d, input logic ld,
                          input logic [2:0] pat, input int exp_y);
      @(negedge clk);
      rst = r;
      if_c.din_valid = v; if_c.din = d; if_c.pat_load = ld; if_c.pat_in = pat;
      sb_c.push_back(exp_y);
      @(posedge clk);
      #1;
      check("dut_c y", int'(if_c.y), sb_c.pop_front());
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      if_a.din_valid = 0; if_a.din = 0; if_a.pat_load = 0; if_a.pat_in = '0;
      if_b.din_valid = 0; if_b.din = 0; if_b.pat_load = 0; if_b.pat_in = '0;
      if_c.din_valid = 0; if_c.din = 0; if_c.pat_load = 0; if_c.pat_in = '0;

      // Reset state
      add(1,0,0,0,4'h0, 0,0, 1, 0,0);
      // Stream 0,1,1,1,0,1,0,1,0,1: A hits after bits 7 and 9, B after 7 only
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 1,1, 1, ecnt(1),ecnt(1));
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 1,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 1, ecnt(2),ecnt(1));
      // "10", load 0110 (din=1 on load cycle discarded), then 0,1,1,0
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,1,4'b0110, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 1,1, 0, 0,0);
      add(0,0,0,0,4'h0, 0,0, 1, ecnt(3),ecnt(2));
      // Reset, "101", reset with a bit offered, "0", then "1010" on the restored pattern
      add(1,0,0,0,4'h0, 0,0, 1, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(1,1,0,0,4'h0, 0,0, 1, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 1,1, 1, ecnt(1),ecnt(1));
      // "1010" with idle gaps and din toggling while invalid
      add(1,0,0,0,4'h0, 0,0, 1, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,0,0,0,4'h0, 0,0, 0, 0,0);
      add(0,0,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 0,0, 0, 0,0);
      add(0,0,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,1,0,4'h0, 0,0, 0, 0,0);
      add(0,0,0,0,4'h0, 0,0, 0, 0,0);
      add(0,0,1,0,4'h0, 0,0, 0, 0,0);
      add(0,1,0,0,4'h0, 1,1, 1, ecnt(1),ecnt(1));
      add(0,0,1,0,4'h0, 0,0, 0, 0,0);
      add(0,0,0,0,4'h0, 0,0, 1, ecnt(1),ecnt(1));

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst;
         if_a.din_valid = tbl[i].vld; if_a.din = tbl[i].d;
         if_a.pat_load  = tbl[i].ld;  if_a.pat_in = tbl[i].pat;
         if_b.din_valid = tbl[i].vld; if_b.din = tbl[i].d;
         if_b.pat_load  = tbl[i].ld;  if_b.pat_in = tbl[i].pat;
         e.ya = tbl[i].ya; e.yb = tbl[i].yb; e.chk = tbl[i].chk;
         e.ca = tbl[i].ca; e.cb = tbl[i].cb;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("vec%0d dut_a y", i), int'(if_a.y), int'(e.ya));
         check($sformatf("vec%0d dut_b y", i), int'(if_b.y), int'(e.yb));
         if (e.chk) begin
            check($sformatf("vec%0d dut_a match_count", i), int'(if_a.match_count), e.ca);
            check($sformatf("vec%0d dut_b match_count", i), int'(if_b.match_count), e.cb);
         end
      end

      @(negedge clk);
      if_a.din_valid = 0; if_a.pat_load = 0;
      if_b.din_valid = 0; if_b.pat_load = 0;

      // DUT C: six 1s keep HIT for 4 cycles; counter saturates at 3
      drive_c(1,0,0,0,3'b000, 0);
      check("dut_c match_count after reset", int'(if_c.match_count), 0);
      drive_c(0,1,1,0,3'b000, 0);
      drive_c(0,1,1,0,3'b000, 0);
      drive_c(0,1,1,0,3'b000, 1);
      drive_c(0,1,1,0,3'b000, 1);
      drive_c(0,1,1,0,3'b000, 1);
      drive_c(0,1,1,0,3'b000, 1);
      check("dut_c match_count saturated", int'(if_c.match_count), ecnt(3));
      // Load while in HIT with a would-be matching bit: y must drop
      drive_c(0,1,1,1,3'b101, 0);
      drive_c(0,1,1,0,3'b000, 0);
      drive_c(0,1,0,0,3'b000, 0);
      drive_c(0,1,1,0,3'b000, 1);
      drive_c(0,0,0,0,3'b000, 0);
      check("dut_c match_count held at max", int'(if_c.match_count), ecnt(3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seq_detect_moore_param
`default_nettype wire
